// File: rtl/tlb_op_unit.sv
`default_nettype none
// ============================================================================
// Module : tlb_op_unit -- TLB maintenance engine (TLBSRCH/RD/WR/FILL/INVTLB)
// Rev    : 1.0
// ============================================================================
module tlb_op_unit #(
  parameter int TLBNUM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tlbsrch_valid,
  input  logic              tlbrd_valid,
  input  logic              tlbwr_valid,
  input  logic              tlbfill_valid,
  input  logic              invtlb_valid,
  output logic              tlbsrch_ready,
  output logic              tlbrd_ready,
  output logic              tlbwr_ready,
  output logic              tlbfill_ready,
  output logic              invtlb_ready,
  input  logic [4:0]        invtlb_op,
  input  logic [31:0]       invtlb_asid,
  input  logic [18:0]       invtlb_va,
  input  logic [9:0]        csr_asid,
  input  logic [18:0]       csr_vppn,
  input  logic [3:0]        csr_index,
  input  logic [5:0]        csr_ps,
  input  logic              csr_ne,
  input  logic [31:0]       csr_elo0,
  input  logic [31:0]       csr_elo1,
  input  logic              csr_refill,
  output logic              srch_we,
  output logic              srch_hit,
  output logic [3:0]        srch_index,
  output logic              rd_we,
  output logic              rd_e,
  output logic              rd_g,
  output logic [18:0]       rd_vppn,
  output logic [5:0]        rd_ps,
  output logic [9:0]        rd_asid,
  output logic [31:0]       rd_elo0,
  output logic [31:0]       rd_elo1,
  output logic              inv_op_err,
  output logic [TLBNUM-1:0] tlb_e
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRCH = 3'd1,
    S_RD   = 3'd2,
    S_WR   = 3'd3,
    S_FILL = 3'd4,
    S_INV  = 3'd5
  } state_t;

  localparam logic [3:0] c_last = 4'(TLBNUM - 1);

  state_t r_state, w_state_nxt;

  // lo fields packed as {PPN[19:0], MAT[1:0], PLV[1:0], D, V}
  logic [TLBNUM-1:0] r_e;
  logic [9:0]        r_t_asid [TLBNUM];
  logic              r_t_g    [TLBNUM];
  logic [5:0]        r_t_ps   [TLBNUM];
  logic [18:0]       r_t_vppn [TLBNUM];
  logic [25:0]       r_t_lo0  [TLBNUM];
  logic [25:0]       r_t_lo1  [TLBNUM];

  logic [9:0]  r_l_asid;
  logic [18:0] r_l_vppn;
  logic [3:0]  r_l_index;
  logic [5:0]  r_l_ps;
  logic        r_l_ne;
  logic        r_l_refill;
  logic [25:0] r_l_lo0;
  logic [25:0] r_l_lo1;
  logic        r_l_g;
  logic [4:0]  r_l_iop;
  logic [9:0]  r_l_iasid;
  logic [18:0] r_l_iva;

  logic [3:0]  r_fill_ptr;
  logic [3:0]  r_inv_idx;

  logic        w_wr_en;
  logic [3:0]  w_wr_idx;
  logic        w_hit;
  logic [3:0]  w_hit_idx;
  logic        w_inv_hit;
  logic        w_inv_asid_eq;
  logic        w_inv_va_eq;
  logic        w_inv_g;
  logic        w_unused_bits;

  assign w_unused_bits = ^{invtlb_asid[31:10], csr_elo0[31:28], csr_elo0[7],
                           csr_elo1[31:28], csr_elo1[7]};

  // Huge pages (PS=21) ignore the low 9 VPPN bits.
  function automatic logic vppn_match(input logic [5:0] ps, input logic [18:0] ent,
                                      input logic [18:0] cmp);
    if (ps == 6'd21) return ent[18:9] == cmp[18:9];
    return ent == cmp;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (tlbsrch_valid)      w_state_nxt = S_SRCH;
        else if (tlbrd_valid)   w_state_nxt = S_RD;
        else if (tlbwr_valid)   w_state_nxt = S_WR;
        else if (tlbfill_valid) w_state_nxt = S_FILL;
        else if (invtlb_valid)  w_state_nxt = S_INV;
      end
      S_INV:   if (r_inv_idx == c_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands follow the inputs while idle and freeze once an op is accepted.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      r_l_asid   <= csr_asid;
      r_l_vppn   <= csr_vppn;
      r_l_index  <= csr_index;
      r_l_ps     <= csr_ps;
      r_l_ne     <= csr_ne;
      r_l_refill <= csr_refill;
      r_l_lo0    <= {csr_elo0[27:8], csr_elo0[5:0]};
      r_l_lo1    <= {csr_elo1[27:8], csr_elo1[5:0]};
      r_l_g      <= csr_elo0[6] & csr_elo1[6];
      r_l_iop    <= invtlb_op;
      r_l_iasid  <= invtlb_asid[9:0];
      r_l_iva    <= invtlb_va;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill_ptr <= '0;
      r_inv_idx  <= '0;
    end else begin
      if (r_state == S_FILL) r_fill_ptr <= r_fill_ptr + 4'd1;
      if (r_state == S_INV)  r_inv_idx  <= r_inv_idx + 4'd1;
      else                   r_inv_idx  <= '0;
    end
  end

  assign w_wr_en  = (r_state == S_WR) || (r_state == S_FILL);
  assign w_wr_idx = (r_state == S_FILL) ? r_fill_ptr : r_l_index;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_t_asid[w_wr_idx] <= r_l_asid;
      r_t_g[w_wr_idx]    <= r_l_g;
      r_t_ps[w_wr_idx]   <= r_l_ps;
      r_t_vppn[w_wr_idx] <= r_l_vppn;
      r_t_lo0[w_wr_idx]  <= r_l_lo0;
      r_t_lo1[w_wr_idx]  <= r_l_lo1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                r_e <= '0;
    else if (w_wr_en)                       r_e[w_wr_idx] <= r_l_refill | ~r_l_ne;
    else if (r_state == S_INV && w_inv_hit) r_e[r_inv_idx] <= 1'b0;
  end

  always_comb begin
    w_inv_asid_eq = (r_t_asid[r_inv_idx] == r_l_iasid);
    w_inv_va_eq   = vppn_match(r_t_ps[r_inv_idx], r_t_vppn[r_inv_idx], r_l_iva);
    w_inv_g       = r_t_g[r_inv_idx];
    case (r_l_iop)
      5'd0, 5'd1: w_inv_hit = 1'b1;
      5'd2:       w_inv_hit = w_inv_g;
      5'd3:       w_inv_hit = ~w_inv_g;
      5'd4:       w_inv_hit = ~w_inv_g & w_inv_asid_eq;
      5'd5:       w_inv_hit = ~w_inv_g & w_inv_asid_eq & w_inv_va_eq;
      5'd6:       w_inv_hit = (w_inv_g | w_inv_asid_eq) & w_inv_va_eq;
      default:    w_inv_hit = 1'b0;
    endcase
  end

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (r_e[i] && (r_t_g[i] || r_t_asid[i] == r_l_asid) &&
          vppn_match(r_t_ps[i], r_t_vppn[i], r_l_vppn)) begin
        w_hit     = 1'b1;
        w_hit_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    tlbsrch_ready <= 1'b0;
    tlbrd_ready   <= 1'b0;
    tlbwr_ready   <= 1'b0;
    tlbfill_ready <= 1'b0;
    invtlb_ready  <= 1'b0;
    inv_op_err    <= 1'b0;
    srch_we       <= 1'b0;
    srch_hit      <= 1'b0;
    srch_index    <= '0;
    rd_we         <= 1'b0;
    rd_e          <= 1'b0;
    rd_g          <= 1'b0;
    rd_vppn       <= '0;
    rd_ps         <= '0;
    rd_asid       <= '0;
    rd_elo0       <= '0;
    rd_elo1       <= '0;
    if (!rst) begin
      case (r_state)
        S_SRCH: begin
          tlbsrch_ready <= 1'b1;
          srch_we       <= 1'b1;
          srch_hit      <= w_hit;
          srch_index    <= w_hit_idx;
        end
        S_RD: begin
          tlbrd_ready <= 1'b1;
          rd_we       <= 1'b1;
          if (r_e[r_l_index]) begin
            rd_e    <= 1'b1;
            rd_g    <= r_t_g[r_l_index];
            rd_vppn <= r_t_vppn[r_l_index];
            rd_ps   <= r_t_ps[r_l_index];
            rd_asid <= r_t_asid[r_l_index];
            rd_elo0 <= {4'b0, r_t_lo0[r_l_index][25:6], 1'b0, r_t_g[r_l_index],
                        r_t_lo0[r_l_index][5:0]};
            rd_elo1 <= {4'b0, r_t_lo1[r_l_index][25:6], 1'b0, r_t_g[r_l_index],
                        r_t_lo1[r_l_index][5:0]};
          end
        end
        S_WR:   tlbwr_ready   <= 1'b1;
        S_FILL: tlbfill_ready <= 1'b1;
        S_INV: begin
          if (r_inv_idx == c_last) begin
            invtlb_ready <= 1'b1;
            inv_op_err   <= (r_l_iop >= 5'd7);
          end
        end
        default: ;
      endcase
    end
  end

  assign tlb_e = r_e;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_tlb_op_unit -- directed + random bench with a transaction model
// Rev    : 1.0
// ============================================================================
module tb_tlb_op_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tlbsrch_valid, tlbrd_valid, tlbwr_valid, tlbfill_valid, invtlb_valid;
  logic        tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready;
  logic [4:0]  invtlb_op;
  logic [31:0] invtlb_asid;
  logic [18:0] invtlb_va;
  logic [9:0]  csr_asid;
  logic [18:0] csr_vppn;
  logic [3:0]  csr_index;
  logic [5:0]  csr_ps;
  logic        csr_ne, csr_refill;
  logic [31:0] csr_elo0, csr_elo1;
  logic        srch_we, srch_hit;
  logic [3:0]  srch_index;
  logic        rd_we, rd_e, rd_g;
  logic [18:0] rd_vppn;
  logic [5:0]  rd_ps;
  logic [9:0]  rd_asid;
  logic [31:0] rd_elo0, rd_elo1;
  logic        inv_op_err;
  logic [15:0] tlb_e;

  tlb_op_unit #(.TLBNUM(16)) dut (
    .clk(clk), .rst(rst),
    .tlbsrch_valid(tlbsrch_valid), .tlbrd_valid(tlbrd_valid), .tlbwr_valid(tlbwr_valid),
    .tlbfill_valid(tlbfill_valid), .invtlb_valid(invtlb_valid),
    .tlbsrch_ready(tlbsrch_ready), .tlbrd_ready(tlbrd_ready), .tlbwr_ready(tlbwr_ready),
    .tlbfill_ready(tlbfill_ready), .invtlb_ready(invtlb_ready),
    .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va),
    .csr_asid(csr_asid), .csr_vppn(csr_vppn), .csr_index(csr_index), .csr_ps(csr_ps),
    .csr_ne(csr_ne), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1), .csr_refill(csr_refill),
    .srch_we(srch_we), .srch_hit(srch_hit), .srch_index(srch_index),
    .rd_we(rd_we), .rd_e(rd_e), .rd_g(rd_g), .rd_vppn(rd_vppn), .rd_ps(rd_ps),
    .rd_asid(rd_asid), .rd_elo0(rd_elo0), .rd_elo1(rd_elo1),
    .inv_op_err(inv_op_err), .tlb_e(tlb_e)
  );

  typedef struct packed {
    logic [4:0]   rdy;   // {srch, rd, wr, fill, inv}
    logic         sw;
    logic         sh;
    logic [3:0]   si;
    logic [101:0] rd;    // {we, e, g, vppn, ps, asid, elo0, elo1}
    logic         err;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   m_known = 1'b0;
  exp_t exp_q [64];
  exp_t cmp_e;

  // Reference TLB contents; lo words kept in CSR layout without the G bit.
  logic [15:0] m_e;
  logic        m_g    [16];
  logic [9:0]  m_asid [16];
  logic [5:0]  m_ps   [16];
  logic [18:0] m_vppn [16];
  logic [31:0] m_lo0  [16];
  logic [31:0] m_lo1  [16];
  int          m_fill, m_op, m_start;
  logic [9:0]  l_asid;
  logic [18:0] l_vppn, l_iva;
  logic [3:0]  l_idx;
  logic [5:0]  l_ps;
  logic        l_ne, l_refill;
  logic [31:0] l_elo0, l_elo1, l_iasid;
  logic [4:0]  l_iop;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic vmatch(input int i, input logic [18:0] v);
    if (m_ps[i] == 6'd21) return m_vppn[i][18:9] == v[18:9];
    return m_vppn[i] == v;
  endfunction

  function automatic logic imatch(input int i);
    logic am, vm;
    am = (m_asid[i] == l_iasid[9:0]);
    vm = vmatch(i, l_iva);
    case (l_iop)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return m_g[i];
      5'd3:       return !m_g[i];
      5'd4:       return !m_g[i] && am;
      5'd5:       return !m_g[i] && am && vm;
      5'd6:       return (m_g[i] || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  // Called once per cycle after the inputs for cycle `cyc` are applied;
  // produces the expected outputs for cycle cyc+1.
  task automatic model();
    exp_t e;
    int   k;
    bit   hit;
    int   hidx;
    e = '0;
    if (rst) begin
      m_e = '0; m_fill = 0; m_op = 0; m_known = 1'b1;
    end else if (m_op == 0) begin
      m_start = cyc;
      l_asid = csr_asid;   l_vppn = csr_vppn;     l_idx = csr_index; l_ps = csr_ps;
      l_ne = csr_ne;       l_refill = csr_refill; l_elo0 = csr_elo0; l_elo1 = csr_elo1;
      l_iop = invtlb_op;   l_iasid = invtlb_asid; l_iva = invtlb_va;
      if (tlbsrch_valid)      m_op = 1;
      else if (tlbrd_valid)   m_op = 2;
      else if (tlbwr_valid)   m_op = 3;
      else if (tlbfill_valid) m_op = 4;
      else if (invtlb_valid)  m_op = 5;
    end else begin
      case (m_op)
        1: begin
          hit = 1'b0; hidx = 0;
          for (int i = 0; i < 16; i++)
            if (!hit && m_e[i] && (m_g[i] || m_asid[i] == l_asid) && vmatch(i, l_vppn)) begin
              hit = 1'b1; hidx = i;
            end
          e.rdy = 5'b10000; e.sw = 1'b1; e.sh = hit; e.si = 4'(hidx);
          m_op = 0;
        end
        2: begin
          k = int'(l_idx);
          e.rdy = 5'b01000;
          if (m_e[k])
            e.rd = {1'b1, 1'b1, m_g[k], m_vppn[k], m_ps[k], m_asid[k],
                    m_lo0[k] | (m_g[k] ? 32'h40 : 32'h0), m_lo1[k] | (m_g[k] ? 32'h40 : 32'h0)};
          else
            e.rd = {1'b1, 101'b0};
          m_op = 0;
        end
        3, 4: begin
          k = (m_op == 3) ? int'(l_idx) : m_fill;
          m_g[k] = l_elo0[6] & l_elo1[6];
          m_asid[k] = l_asid; m_ps[k] = l_ps; m_vppn[k] = l_vppn;
          m_lo0[k] = l_elo0 & 32'h0FFF_FF3F;
          m_lo1[k] = l_elo1 & 32'h0FFF_FF3F;
          m_e[k] = l_refill | !l_ne;
          if (m_op == 4) begin
            m_fill = (m_fill + 1) % 16;
            e.rdy = 5'b00010;
          end else begin
            e.rdy = 5'b00100;
          end
          m_op = 0;
        end
        default: begin
          k = cyc - m_start - 1;
          if (l_iop < 5'd7 && imatch(k)) m_e[k] = 1'b0;
          if (k == 15) begin
            e.rdy = 5'b00001; e.err = (l_iop >= 5'd7); m_op = 0;
          end
        end
      endcase
    end
    if (m_known) exp_q[(cyc + 1) % 64] = e;
  endtask

  always @(posedge clk) begin
    #1;
    if (m_known) begin
      cmp_e = exp_q[cyc % 64];
      exp_q[cyc % 64] = '0;
      chk("ready", {tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready}, cmp_e.rdy);
      chk("srch", {srch_we, srch_hit, srch_index}, {cmp_e.sw, cmp_e.sh, cmp_e.si});
      chk("rd", {rd_we, rd_e, rd_g, rd_vppn, rd_ps, rd_asid, rd_elo0, rd_elo1}, cmp_e.rd);
      chk("inv_op_err", inv_op_err, cmp_e.err);
      chk("tlb_e", tlb_e, m_e);
    end
  end

  task automatic step();
    model();
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    tlbsrch_valid = 1'b0; tlbrd_valid = 1'b0; tlbwr_valid = 1'b0;
    tlbfill_valid = 1'b0; invtlb_valid = 1'b0;
  endtask

  task automatic write_op(input bit fill, input logic [3:0] idx, input logic [18:0] vppn,
                          input logic [5:0] ps, input logic [9:0] asid,
                          input logic [31:0] e0, input logic [31:0] e1);
    csr_index = idx; csr_vppn = vppn; csr_ps = ps; csr_asid = asid;
    csr_elo0 = e0; csr_elo1 = e1; csr_ne = 1'b0; csr_refill = 1'b0;
    if (fill) tlbfill_valid = 1'b1;
    else      tlbwr_valid = 1'b1;
    step(); step();
  endtask

  task automatic search(input logic [9:0] asid, input logic [18:0] vppn);
    csr_asid = asid; csr_vppn = vppn; tlbsrch_valid = 1'b1;
    step(); step();
  endtask

  task automatic inv_to_end(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] va);
    invtlb_op = op; invtlb_asid = {22'h0, asid}; invtlb_va = va; invtlb_valid = 1'b1;
    repeat (16) step();
    chk("inv_ready_T16", invtlb_ready, 1'b0);
    step();
    chk("inv_ready_T17", invtlb_ready, 1'b1);
  endtask

  function automatic logic [18:0] vpool();
    case ($urandom % 4)
      0:       return 19'h12345;
      1:       return 19'h12200;
      2:       return 19'h123FF;
      default: return 19'($urandom);
    endcase
  endfunction

  initial begin
    int seen;
    foreach (exp_q[i]) exp_q[i] = '0;
    m_e = '0; m_op = 0; m_fill = 0; m_start = 0;
    rst = 1'b1;
    tlbsrch_valid = 1'b0; tlbrd_valid = 1'b0; tlbwr_valid = 1'b0;
    tlbfill_valid = 1'b0; invtlb_valid = 1'b0;
    invtlb_op = '0; invtlb_asid = '0; invtlb_va = '0;
    csr_asid = '0; csr_vppn = '0; csr_index = '0; csr_ps = '0;
    csr_ne = 1'b0; csr_refill = 1'b0; csr_elo0 = '0; csr_elo1 = '0;
    @(negedge clk);
    rst = 1'b1; step();
    rst = 1'b1; step();
    chk("reset_tlb_e", tlb_e, 16'h0000);
    chk("reset_ready", {tlbsrch_ready, tlbrd_ready, tlbwr_ready, tlbfill_ready, invtlb_ready}, 5'b0);

    // PPN field [27:8] of 0x0100_0013 is 0x10000
    write_op(1'b0, 4'd3, 19'h12345, 6'd12, 10'd5, 32'h0100_0013, 32'h0000_0001);
    chk("wr_ready", tlbwr_ready, 1'b1);
    chk("wr_tlb_e", tlb_e, 16'h0008);
    step();
    csr_index = 4'd3; tlbrd_valid = 1'b1;
    step(); step();
    chk("rd_e", rd_e, 1'b1);
    chk("rd_vppn", rd_vppn, 19'h12345);
    chk("rd_ppn0", rd_elo0[27:8], 20'h10000);

    search(10'd5, 19'h12345);
    chk("srch_hit", srch_hit, 1'b1);
    chk("srch_index", srch_index, 4'd3);
    search(10'd6, 19'h12345);
    chk("srch_miss", srch_hit, 1'b0);

    write_op(1'b0, 4'd7, 19'h12200, 6'd21, 10'd1, 32'h0000_0040, 32'h0000_0040);
    search(10'd2, 19'h123FF);
    chk("huge_hit", srch_hit, 1'b1);
    chk("huge_index", srch_index, 4'd7);

    rst = 1'b1; step();
    write_op(1'b1, 4'd9, 19'h0ABCD, 6'd12, 10'd5, 32'h0000_0001, 32'h0000_0001);
    write_op(1'b1, 4'd9, 19'h0ABCD, 6'd12, 10'd9, 32'h0000_0041, 32'h0000_0041);
    write_op(1'b1, 4'd9, 19'h00111, 6'd12, 10'd5, 32'h0000_0001, 32'h0000_0001);
    chk("fill_tlb_e", tlb_e, 16'h0007);

    inv_to_end(5'd5, 10'd5, 19'h0ABCD);
    chk("inv5_tlb_e", tlb_e, 16'h0006);
    chk("inv5_err", inv_op_err, 1'b0);
    inv_to_end(5'd9, 10'd5, 19'h0ABCD);
    chk("inv9_err", inv_op_err, 1'b1);
    chk("inv9_tlb_e", tlb_e, 16'h0006);

    csr_index = 4'd0; csr_ne = 1'b0; csr_asid = 10'd5; csr_vppn = 19'h0ABCD;
    tlbsrch_valid = 1'b1; tlbwr_valid = 1'b1;
    step(); step();
    chk("simul_srch_ready", tlbsrch_ready, 1'b1);
    chk("simul_wr_ready", tlbwr_ready, 1'b0);
    chk("simul_index", srch_index, 4'd1);
    step();
    chk("simul_tlb_e", tlb_e, 16'h0006);

    invtlb_op = 5'd0; invtlb_valid = 1'b1;
    step();
    repeat (7) step();
    rst = 1'b1; step();
    chk("inv_rst_tlb_e", tlb_e, 16'h0000);
    seen = 0;
    repeat (12) begin
      step();
      seen += int'(invtlb_ready);
    end
    chk("inv_rst_no_ready", seen, 0);

    repeat (3000) begin
      rst           = (($urandom % 300) == 0);
      tlbsrch_valid = (($urandom % 6) == 0);
      tlbrd_valid   = (($urandom % 6) == 0);
      tlbwr_valid   = (($urandom % 6) == 0);
      tlbfill_valid = (($urandom % 6) == 0);
      invtlb_valid  = (($urandom % 12) == 0);
      invtlb_op     = 5'($urandom % 10);
      invtlb_asid   = ($urandom & 32'hFFFF_FC00) | ($urandom % 4);
      invtlb_va     = vpool();
      csr_asid      = 10'($urandom % 4);
      csr_vppn      = vpool();
      csr_index     = 4'($urandom);
      case ($urandom % 3)
        0:       csr_ps = 6'd21;
        1:       csr_ps = 6'd12;
        default: csr_ps = 6'($urandom);
      endcase
      csr_ne        = (($urandom % 4) == 0);
      csr_refill    = (($urandom % 8) == 0);
      csr_elo0      = $urandom;
      csr_elo1      = $urandom;
      if ($urandom % 2) begin
        csr_elo0 = csr_elo0 | 32'h40;
        csr_elo1 = csr_elo1 | 32'h40;
      end
      step();
    end
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
